// File: rtl/regfile_write_arbiter_if.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter_if
//   Bundles the two writeback requester handshakes (port 0 = ALU writeback,
//   port 1 = load writeback) that feed regfile_write_arbiter.
//
//   Handshake: a requester raises reqN_valid with reqN_addr/reqN_data stable;
//   the transfer happens on the rising clock edge where reqN_valid and
//   reqN_ready are both 1. reqN_ready may depend combinationally on
//   reqN_valid, and the requester must not drop or change a request that has
//   not been accepted.
//
//   Ports / modports:
//     master : requester side; drives valid/addr/data and samples ready
//     slave  : arbiter side; samples valid/addr/data and drives ready
// ---------------------------------------------------------------------------
interface regfile_write_arbiter_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
);
  logic              req0_valid;
  logic              req0_ready;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req1_valid;
  logic              req1_ready;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_write_arbiter
//   Shares the single register-file write port between the ALU writeback
//   (port 0) and the load writeback (port 1). Requests are arbitrated
//   round-robin into a one-entry registered write stage; the stage drives a
//   one-hot write enable for the NREG register instances plus common data.
//   Register NREG-1 is hardwired zero: writes to it complete the handshake
//   but never raise a write enable.
//
//   Optional feature: define READ_BYPASS_EN to forward the pending stage
//   data onto rd_data when the read address matches. Without the macro,
//   rd_data is rd_data_reg unchanged.
//
//   Ports:
//     clk          clock, rising edge
//     reset        asynchronous active-low reset
//     req          requester handshakes (slave modport)
//     hold         register-file write port blocked; stage must not drain
//     wr_en        one-hot write enable (zero when idle / held / X31)
//     wr_data      write data to the register file
//     rd_addr      read address presented to the register file
//     rd_data_reg  raw read data from the register file
//     rd_data      read data after the optional bypass
//     busy         write stage holds a pending write (stage valid)
// ---------------------------------------------------------------------------
module regfile_write_arbiter #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5,
  parameter int NREG   = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  regfile_write_arbiter_if.slave req,
  input  logic                 hold,
  output logic [NREG-1:0]      wr_en,
  output logic [DATA_W-1:0]    wr_data,
  input  logic [ADDR_W-1:0]    rd_addr,
  input  logic [DATA_W-1:0]    rd_data_reg,
  output logic [DATA_W-1:0]    rd_data,
  output logic                 busy
);

  localparam logic [ADDR_W-1:0] ZERO_REG = ADDR_W'(NREG - 1);

  logic              stage_valid_q, stage_valid_d;
  logic [ADDR_W-1:0] stage_addr_q,  stage_addr_d;
  logic [DATA_W-1:0] stage_data_q,  stage_data_d;
  logic              last_grant_q,  last_grant_d;

  logic accept_ok;
  logic grant_vld;
  logic grant_sel;
  logic accept;

  // The stage can take a new entry if it is empty or draining this cycle.
  assign accept_ok = !stage_valid_q || !hold;

  // Round-robin: on a tie the requester that did not win last time wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_sel = 1'b0;
    case ({req.req1_valid, req.req0_valid})
      2'b01:   begin grant_vld = 1'b1; grant_sel = 1'b0;          end
      2'b10:   begin grant_vld = 1'b1; grant_sel = 1'b1;          end
      2'b11:   begin grant_vld = 1'b1; grant_sel = ~last_grant_q; end
      default: begin grant_vld = 1'b0; grant_sel = 1'b0;          end
    endcase
  end

  assign accept = grant_vld && accept_ok;

  // Readies are forced low while reset is asserted so no handshake can be
  // seen by a requester during reset.
  assign req.req0_ready = accept && !grant_sel && reset;
  assign req.req1_ready = accept &&  grant_sel && reset;

  always_comb begin
    stage_valid_d = stage_valid_q;
    stage_addr_d  = stage_addr_q;
    stage_data_d  = stage_data_q;
    last_grant_d  = last_grant_q;
    if (stage_valid_q && !hold) begin
      stage_valid_d = 1'b0;
    end
    // An accept in the same cycle as a drain replaces the entry directly.
    if (accept) begin
      stage_valid_d = 1'b1;
      stage_addr_d  = grant_sel ? req.req1_addr : req.req0_addr;
      stage_data_d  = grant_sel ? req.req1_data : req.req0_data;
      last_grant_d  = grant_sel;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stage_valid_q <= 1'b0;
      stage_addr_q  <= '0;
      stage_data_q  <= '0;
      last_grant_q  <= 1'b1;
    end else begin
      stage_valid_q <= stage_valid_d;
      stage_addr_q  <= stage_addr_d;
      stage_data_q  <= stage_data_d;
      last_grant_q  <= last_grant_d;
    end
  end

  always_comb begin
    wr_en = '0;
    if (stage_valid_q && !hold && (stage_addr_q != ZERO_REG)) begin
      wr_en = NREG'(1) << stage_addr_q;
    end
  end

  assign wr_data = stage_data_q;
  assign busy    = stage_valid_q;

`ifdef READ_BYPASS_EN
  // Forward the pending write so a read of its target sees the new value,
  // including while the write port is held.
  always_comb begin
    rd_data = rd_data_reg;
    if (stage_valid_q && (stage_addr_q == rd_addr) && (rd_addr != ZERO_REG)) begin
      rd_data = stage_data_q;
    end
  end
`else
  assign rd_data = rd_data_reg;
  // rd_addr only matters when the bypass is built in.
  logic unused_rd_addr;
  assign unused_rd_addr = ^rd_addr;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_write_arbiter
//   Directed bench for regfile_write_arbiter. Inputs change 1 time unit after
//   a rising edge; outputs are sampled on the falling edge (or a few units
//   after an asynchronous reset change).
// ---------------------------------------------------------------------------
module tb_regfile_write_arbiter;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;
  localparam int NREG   = 32;

`ifdef READ_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic              clk;
  logic              reset;
  logic              hold;
  logic [NREG-1:0]   wr_en;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data_reg;
  logic [DATA_W-1:0] rd_data;
  logic              busy;

  int checks;
  int errors;

  regfile_write_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) rif ();

  regfile_write_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREG(NREG)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (rif.slave),
    .hold        (hold),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .rd_addr     (rd_addr),
    .rd_data_reg (rd_data_reg),
    .rd_data     (rd_data),
    .busy        (busy)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rif.req0_valid = 1'b0; rif.req0_addr = '0; rif.req0_data = '0;
    rif.req1_valid = 1'b0; rif.req1_addr = '0; rif.req1_data = '0;
    hold = 1'b0; rd_addr = '0; rd_data_reg = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  task automatic drive0(input logic v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    rif.req0_valid = v; rif.req0_addr = a; rif.req0_data = d;
  endtask

  task automatic drive1(input logic v, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    rif.req1_valid = v; rif.req1_addr = a; rif.req1_data = d;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    drive0(1'b1, 5'd3, 64'h1);
    drive1(1'b1, 5'd4, 64'h2);
    @(negedge clk);
    checks++; if (rif.req0_ready !== 1'b0) begin errors++; $display("FAIL reset_ready0: got %b expected 0", rif.req0_ready); end
    checks++; if (rif.req1_ready !== 1'b0) begin errors++; $display("FAIL reset_ready1: got %b expected 0", rif.req1_ready); end
    checks++; if (wr_en !== '0) begin errors++; $display("FAIL reset_wr_en: got %h expected 0", wr_en); end
    checks++; if (wr_data !== '0) begin errors++; $display("FAIL reset_wr_data: got %h expected 0", wr_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    drive0(1'b0, '0, '0);
    drive1(1'b0, '0, '0);
    next_cycle();
    reset = 1'b1;
  endtask

  task automatic test_single_write();
    drive0(1'b1, 5'd3, 64'hAA);
    @(negedge clk);
    checks++; if (rif.req0_ready !== 1'b1) begin errors++; $display("FAIL single_ready0: got %b expected 1", rif.req0_ready); end
    checks++; if (rif.req1_ready !== 1'b0) begin errors++; $display("FAIL single_ready1: got %b expected 0", rif.req1_ready); end
    checks++; if (wr_en !== '0) begin errors++; $display("FAIL single_wr_en_pre: got %h expected 0", wr_en); end
    next_cycle();
    drive0(1'b0, '0, '0);
    @(negedge clk);
    checks++; if (wr_en !== 32'h8) begin errors++; $display("FAIL single_wr_en: got %h expected 00000008", wr_en); end
    checks++; if (wr_data !== 64'hAA) begin errors++; $display("FAIL single_wr_data: got %h expected aa", wr_data); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", busy); end
    next_cycle();
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_after: got %b expected 0", busy); end
    checks++; if (wr_en !== '0) begin errors++; $display("FAIL single_wr_en_after: got %h expected 0", wr_en); end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    logic [NREG-1:0] exp_we [4];
    logic            exp_r0;
    exp_we[0] = 32'h0; exp_we[1] = 32'h2; exp_we[2] = 32'h4; exp_we[3] = 32'h2;
    do_reset();
    drive0(1'b1, 5'd1, 64'h11);
    drive1(1'b1, 5'd2, 64'h22);
    for (int k = 0; k < 4; k++) begin
      exp_r0 = (k % 2 == 0);
      @(negedge clk);
      checks++; if (rif.req0_ready !== exp_r0) begin errors++; $display("FAIL b2b_ready0[%0d]: got %b expected %b", k, rif.req0_ready, exp_r0); end
      checks++; if (rif.req1_ready !== !exp_r0) begin errors++; $display("FAIL b2b_ready1[%0d]: got %b expected %b", k, rif.req1_ready, !exp_r0); end
      checks++; if (wr_en !== exp_we[k]) begin errors++; $display("FAIL b2b_wr_en[%0d]: got %h expected %h", k, wr_en, exp_we[k]); end
      next_cycle();
    end
    drive0(1'b0, '0, '0);
    drive1(1'b0, '0, '0);
    @(negedge clk);
    checks++; if (wr_en !== 32'h4) begin errors++; $display("FAIL b2b_wr_en_last: got %h expected 00000004", wr_en); end
    checks++; if (wr_data !== 64'h22) begin errors++; $display("FAIL b2b_wr_data_last: got %h expected 22", wr_data); end
    next_cycle();
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_end: got %b expected 0", busy); end
    next_cycle();
  endtask

  task automatic test_hold();
    // Stage full and held: nothing drains, nothing is accepted.
    drive0(1'b1, 5'd7, 64'h77);
    @(negedge clk);
    checks++; if (rif.req0_ready !== 1'b1) begin errors++; $display("FAIL hold_fill_ready0: got %b expected 1", rif.req0_ready); end
    next_cycle();
    drive0(1'b0, '0, '0);
    drive1(1'b1, 5'd9, 64'h99);
    hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (wr_en !== '0) begin errors++; $display("FAIL hold_wr_en[%0d]: got %h expected 0", k, wr_en); end
      checks++; if (rif.req0_ready !== 1'b0 || rif.req1_ready !== 1'b0) begin errors++; $display("FAIL hold_ready[%0d]: got %b%b expected 00", k, rif.req1_ready, rif.req0_ready); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL hold_busy[%0d]: got %b expected 1", k, busy); end
      checks++; if (wr_data !== 64'h77) begin errors++; $display("FAIL hold_wr_data[%0d]: got %h expected 77", k, wr_data); end
      next_cycle();
    end
    hold = 1'b0;
    @(negedge clk);
    checks++; if (wr_en !== 32'h80) begin errors++; $display("FAIL hold_release_wr_en: got %h expected 00000080", wr_en); end
    checks++; if (rif.req1_ready !== 1'b1) begin errors++; $display("FAIL hold_release_ready1: got %b expected 1", rif.req1_ready); end
    next_cycle();
    drive1(1'b0, '0, '0);
    @(negedge clk);
    checks++; if (wr_en !== 32'h200) begin errors++; $display("FAIL hold_next_wr_en: got %h expected 00000200", wr_en); end
    checks++; if (wr_data !== 64'h99) begin errors++; $display("FAIL hold_next_wr_data: got %h expected 99", wr_data); end
    next_cycle();
    // Stage empty and held: one request is taken, then the stage stalls.
    hold = 1'b1;
    drive0(1'b1, 5'd4, 64'h44);
    @(negedge clk);
    checks++; if (rif.req0_ready !== 1'b1) begin errors++; $display("FAIL hold_empty_ready0: got %b expected 1", rif.req0_ready); end
    next_cycle();
    drive0(1'b1, 5'd8, 64'h88);
    @(negedge clk);
    checks++; if (rif.req0_ready !== 1'b0) begin errors++; $display("FAIL hold_stall_ready0: got %b expected 0", rif.req0_ready); end
    checks++; if (wr_en !== '0) begin errors++; $display("FAIL hold_stall_wr_en: got %h expected 0", wr_en); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL hold_stall_busy: got %b expected 1", busy); end
    next_cycle();
    hold = 1'b0;
    drive0(1'b0, '0, '0);
    @(negedge clk);
    checks++; if (wr_en !== 32'h10) begin errors++; $display("FAIL hold_stall_drain_wr_en: got %h expected 00000010", wr_en); end
    checks++; if (wr_data !== 64'h44) begin errors++; $display("FAIL hold_stall_drain_wr_data: got %h expected 44", wr_data); end
    next_cycle();
  endtask

  task automatic test_x31();
    // last grant was req0; req1 alone now takes the hardwired-zero register.
    drive1(1'b1, 5'd31, 64'hFF);
    @(negedge clk);
    checks++; if (rif.req1_ready !== 1'b1) begin errors++; $display("FAIL x31_ready1: got %b expected 1", rif.req1_ready); end
    next_cycle();
    drive1(1'b0, '0, '0);
    @(negedge clk);
    checks++; if (wr_en !== '0) begin errors++; $display("FAIL x31_wr_en: got %h expected 0", wr_en); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL x31_busy: got %b expected 1", busy); end
    checks++; if (wr_data !== 64'hFF) begin errors++; $display("FAIL x31_wr_data: got %h expected ff", wr_data); end
    next_cycle();
    drive0(1'b1, 5'd1, 64'h11);
    drive1(1'b1, 5'd2, 64'h22);
    @(negedge clk);
    checks++; if (rif.req0_ready !== 1'b1) begin errors++; $display("FAIL x31_tie_ready0: got %b expected 1", rif.req0_ready); end
    checks++; if (rif.req1_ready !== 1'b0) begin errors++; $display("FAIL x31_tie_ready1: got %b expected 0", rif.req1_ready); end
    next_cycle();
    drive0(1'b0, '0, '0);
    drive1(1'b0, '0, '0);
    @(negedge clk);
    checks++; if (wr_en !== 32'h2) begin errors++; $display("FAIL x31_tie_wr_en: got %h expected 00000002", wr_en); end
    next_cycle();
  endtask

  task automatic test_reset_mid();
    // last grant is req0 here; after reset the tie must go back to req0.
    drive0(1'b1, 5'd6, 64'h66);
    @(negedge clk);
    checks++; if (rif.req0_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready0: got %b expected 1", rif.req0_ready); end
    next_cycle();
    drive0(1'b0, '0, '0);
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_pending: got %b expected 1", busy); end
    reset = 1'b0;
    drive0(1'b1, 5'd1, 64'h11);
    drive1(1'b1, 5'd2, 64'h22);
    #1;
    checks++; if (wr_en !== '0) begin errors++; $display("FAIL rmid_wr_en: got %h expected 0", wr_en); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b expected 0", busy); end
    checks++; if (wr_data !== '0) begin errors++; $display("FAIL rmid_wr_data: got %h expected 0", wr_data); end
    checks++; if (rif.req0_ready !== 1'b0 || rif.req1_ready !== 1'b0) begin errors++; $display("FAIL rmid_ready: got %b%b expected 00", rif.req1_ready, rif.req0_ready); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (wr_en !== '0) begin errors++; $display("FAIL rmid_release_wr_en: got %h expected 0", wr_en); end
    checks++; if (rif.req0_ready !== 1'b1 || rif.req1_ready !== 1'b0) begin errors++; $display("FAIL rmid_tie: got %b%b expected 01", rif.req1_ready, rif.req0_ready); end
    next_cycle();
    drive0(1'b0, '0, '0);
    drive1(1'b0, '0, '0);
    @(negedge clk);
    checks++; if (wr_en !== 32'h2) begin errors++; $display("FAIL rmid_wr_en_after: got %h expected 00000002", wr_en); end
    checks++; if (wr_data !== 64'h11) begin errors++; $display("FAIL rmid_wr_data_after: got %h expected 11", wr_data); end
    next_cycle();
  endtask

  task automatic test_read_bypass();
    logic [DATA_W-1:0] exp_rd;
    drive0(1'b1, 5'd5, 64'h1234);
    rd_addr = 5'd5;
    rd_data_reg = '0;
    @(negedge clk);
    checks++; if (rd_data !== 64'h0) begin errors++; $display("FAIL byp_empty: got %h expected 0", rd_data); end
    next_cycle();
    drive0(1'b0, '0, '0);
    hold = 1'b1;
    @(negedge clk);
    exp_rd = BYPASS ? 64'h1234 : 64'h0;
    checks++; if (rd_data !== exp_rd) begin errors++; $display("FAIL byp_match: got %h expected %h", rd_data, exp_rd); end
    rd_addr = 5'd31;
    rd_data_reg = 64'h5555;
    #1;
    checks++; if (rd_data !== 64'h5555) begin errors++; $display("FAIL byp_x31: got %h expected 5555", rd_data); end
    rd_addr = 5'd6;
    #1;
    checks++; if (rd_data !== 64'h5555) begin errors++; $display("FAIL byp_other: got %h expected 5555", rd_data); end
    next_cycle();
    hold = 1'b0;
    next_cycle();
    rd_addr = 5'd5;
    rd_data_reg = 64'h7777;
    @(negedge clk);
    checks++; if (rd_data !== 64'h7777) begin errors++; $display("FAIL byp_drained: got %h expected 7777", rd_data); end
    next_cycle();
    clear_inputs();
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    clear_inputs();
    test_reset();
    test_single_write();
    test_back_to_back();
    test_hold();
    test_x31();
    test_reset_mid();
    test_read_bypass();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
